// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
package imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    // addi x0,x0,0
    localparam logic [31:0] IMEM_NOP_DEFAULT = 32'h0000_0013;

    // Two bits select one of the four byte lanes of a 32-bit word.
    localparam int LANE_CNT_W = 2;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs the byte-serial boot stream little-endian into words and issues store writes.
// Zero latency: the completed word is written on the edge that accepts its final byte.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          en,
    input  logic          boot_valid,
    input  logic [7:0]    boot_byte,
    input  logic          boot_last,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          done
);

    logic [LANE_CNT_W-1:0] cnt;
    logic [7:0]            lanes [1 << LANE_CNT_W];
    logic [AW-1:0]         wptr;
    logic                  take;

    assign take    = en && boot_valid;
    assign wr_en   = take && (boot_last || (&cnt));
    assign wr_addr = wptr;
    assign done    = wr_en && (boot_last || (wptr == AW'(DEPTH - 1)));

    // Lanes below the counter come from earlier bytes, the current byte fills
    // its own lane, and lanes above stay zero for a short final word.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < (1 << LANE_CNT_W); i++) begin
            if (i < int'(cnt)) begin
                wr_data[8*i +: 8] = lanes[i];
            end else if (i == int'(cnt)) begin
                wr_data[8*i +: 8] = boot_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            lanes[cnt] <= boot_byte;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt  <= '0;
            wptr <= '0;
        end else if (take) begin
            if (wr_en) begin
                cnt  <= '0;
                wptr <= wptr + 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader_rom.sv
// Instruction memory filled from a boot byte stream; holds the core off until loaded.
// Optional macro IMEM_FAULT_EN flags and NOPs misaligned or out-of-range fetches.
module imem_loader_rom
    import imem_pkg::*;
#(
    parameter int                WORD_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [WORD_W-1:0] NOP_WORD = IMEM_NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] Iaddress,
    output logic [WORD_W-1:0] instr,
    input  logic              boot_valid,
    input  logic [7:0]        boot_byte,
    input  logic              boot_last,
    output logic              boot_ready,
    output logic              core_run,
    output logic              fault
);

    localparam int AW = $clog2(DEPTH);

    imem_state_t       state, next_state;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_data;
    logic              done;
    logic [AW-1:0]     ridx;
    logic [WORD_W-1:0] store [DEPTH];

    assign boot_ready = (state == LOAD);
    assign core_run   = (state == RUN);
    assign ridx       = Iaddress[AW+1:2];

    imem_byte_packer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_packer (
        .clk        (clk),
        .n_reset    (n_reset),
        .en         (boot_ready),
        .boot_valid (boot_valid),
        .boot_byte  (boot_byte),
        .boot_last  (boot_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == LOAD && done) begin
            next_state = RUN;
        end
    end

    // Contents are not reset; unwritten words read back undefined.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
    end

`ifdef IMEM_FAULT_EN
    always_comb begin
        fault = 1'b0;
        instr = NOP_WORD;
        if (state == RUN) begin
            fault = (Iaddress[1:0] != 2'b00) || (Iaddress[WORD_W-1:AW+2] != '0);
            if (!fault) begin
                instr = store[ridx];
            end
        end
    end
`else
    // Byte offset and high bits are dropped, so fetches wrap around the store.
    logic unused_addr;
    assign unused_addr = ^{Iaddress[1:0], Iaddress[WORD_W-1:AW+2]};

    always_comb begin
        fault = 1'b0;
        instr = NOP_WORD;
        if (state == RUN) begin
            instr = store[ridx];
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader_rom.sv
// Directed bench for imem_loader_rom: a 256-word instance and a 4-word instance.
module tb_imem_loader_rom;

`ifdef IMEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h00A0_0513;
    localparam logic [31:0] W1  = 32'h00B0_0593;
    localparam logic [31:0] W2  = 32'h0000_0093;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;

    logic [31:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_instr, b_instr;
    logic        a_vld = 1'b0, b_vld = 1'b0;
    logic [7:0]  a_byte = '0, b_byte = '0;
    logic        a_last = 1'b0, b_last = 1'b0;
    logic        a_rdy, b_rdy, a_run, b_run, a_fault, b_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader_rom #(.DEPTH(256)) u_dut (
        .clk(clk), .n_reset(n_reset), .Iaddress(a_addr), .instr(a_instr),
        .boot_valid(a_vld), .boot_byte(a_byte), .boot_last(a_last),
        .boot_ready(a_rdy), .core_run(a_run), .fault(a_fault)
    );

    imem_loader_rom #(.DEPTH(4)) u_small (
        .clk(clk), .n_reset(n_reset), .Iaddress(b_addr), .instr(b_instr),
        .boot_valid(b_vld), .boot_byte(b_byte), .boot_last(b_last),
        .boot_ready(b_rdy), .core_run(b_run), .fault(b_fault)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
        tick();
    endtask

    task automatic send_a(input logic [7:0] b, input logic l);
        a_vld = 1'b1; a_byte = b; a_last = l;
        tick();
        a_vld = 1'b0; a_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input logic l);
        b_vld = 1'b1; b_byte = b; b_last = l;
        tick();
        b_vld = 1'b0; b_last = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            a_byte = 8'hEE; a_last = 1'b1;
            tick();
            check("idle_ready", 32'(a_rdy), 32'd1);
            check("idle_run", 32'(a_run), 32'd0);
        end
        a_last = 1'b0;
    endtask

    logic [31:0] exp_small [4];

    initial begin
        #2;
        check("rst_ready", 32'(a_rdy), 32'd1);
        check("rst_run", 32'(a_run), 32'd0);
        check("rst_fault", 32'(a_fault), 32'd0);
        check("rst_instr", a_instr, NOP);
        do_reset();
        check("rst_small_ready", 32'(b_rdy), 32'd1);
        check("rst_small_instr", b_instr, NOP);

        // Basic load with gating and idle cycles mid-word
        a_addr = 32'h40;
        send_a(8'h13, 1'b0);
        send_a(8'h05, 1'b0);
        check("load_gate_instr", a_instr, NOP);
        check("load_gate_run", 32'(a_run), 32'd0);
        idle_a(3);
        send_a(8'hA0, 1'b0);
        check("pre_last_run", 32'(a_run), 32'd0);
        send_a(8'h00, 1'b1);
        check("basic_run", 32'(a_run), 32'd1);
        check("basic_ready", 32'(a_rdy), 32'd0);
        a_addr = 32'h0;
        #1;
        check("basic_word0", a_instr, W0);

        // Partial final word
        do_reset();
        check("reload_instr", a_instr, NOP);
        send_a(8'h13, 1'b0); send_a(8'h05, 1'b0); send_a(8'hA0, 1'b0); send_a(8'h00, 1'b0);
        send_a(8'h93, 1'b0); send_a(8'h05, 1'b0); send_a(8'hB0, 1'b0); send_a(8'h00, 1'b0);
        check("partial_ready_before", 32'(a_rdy), 32'd1);
        send_a(8'h93, 1'b1);
        check("partial_ready_after", 32'(a_rdy), 32'd0);
        check("partial_run", 32'(a_run), 32'd1);

        vecs[0] = '{"rd_w0",     32'h0000_0000, W0, 1'b0};
        vecs[1] = '{"rd_w1",     32'h0000_0004, W1, 1'b0};
        vecs[2] = '{"rd_w2",     32'h0000_0008, W2, 1'b0};
        vecs[3] = '{"rd_mis2",   32'h0000_0002, FE ? NOP : W0, FE};
        vecs[4] = '{"rd_mis6",   32'h0000_0006, FE ? NOP : W1, FE};
        vecs[5] = '{"rd_mis9",   32'h0000_0009, FE ? NOP : W2, FE};
        vecs[6] = '{"rd_oor",    32'h0000_0400, FE ? NOP : W0, FE};
        vecs[7] = '{"rd_oor4",   32'h0000_0404, FE ? NOP : W1, FE};
        vecs[8] = '{"rd_oor8",   32'h0000_0408, FE ? NOP : W2, FE};
        vecs[9] = '{"rd_top",    32'h8000_0000, FE ? NOP : W0, FE};
        for (int i = 0; i < 10; i++) begin
            a_addr = vecs[i].addr;
            #1;
            check({vecs[i].name, "_instr"}, a_instr, vecs[i].instr);
            check({vecs[i].name, "_fault"}, 32'(a_fault), 32'(vecs[i].fault));
        end
        tick();

        // Reset mid-load discards the partial word and pointer
        do_reset();
        for (int i = 0; i < 6; i++) send_a(8'hAA + 8'(i), 1'b0);
        do_reset();
        check("midrst_run", 32'(a_run), 32'd0);
        check("midrst_ready", 32'(a_rdy), 32'd1);
        send_a(8'h37, 1'b0); send_a(8'h01, 1'b0); send_a(8'h00, 1'b0);
        send_a(8'h10, 1'b1);
        a_addr = 32'h0;
        #1;
        check("midrst_run_after", 32'(a_run), 32'd1);
        check("midrst_word0", a_instr, 32'h1000_0137);

        // Full-store auto-terminate on the 4-word instance
        for (int k = 0; k < 4; k++)
            exp_small[k] = {8'h13 + 8'(4*k), 8'h12 + 8'(4*k), 8'h11 + 8'(4*k), 8'h10 + 8'(4*k)};
        for (int i = 0; i < 15; i++) send_b(8'h10 + 8'(i), 1'b0);
        check("full_run_before", 32'(b_run), 32'd0);
        check("full_ready_before", 32'(b_rdy), 32'd1);
        send_b(8'h1F, 1'b0);
        check("full_run", 32'(b_run), 32'd1);
        check("full_ready", 32'(b_rdy), 32'd0);
        send_b(8'h77, 1'b0);
        check("full_extra_ready", 32'(b_rdy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            b_addr = 32'(4*k);
            #1;
            check($sformatf("full_word%0d", k), b_instr, exp_small[k]);
        end
        b_addr = 32'd16;
        #1;
        check("full_oor_instr", b_instr, FE ? NOP : exp_small[0]);
        check("full_oor_fault", 32'(b_fault), 32'(FE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader_rom.md
# imem_loader_rom

Instruction-memory responder for the single-cycle RV32 core: the consumer end of the program counter's `Iaddress` bus.

- Holds a word-addressed instruction store and returns `instr` combinationally for the current `Iaddress`.
- Fills its store at boot from a byte-serial loader stream.
- Holds the core off via `core_run` until loading completes, and substitutes a NOP for illegal fetches.

## Interface
Parameters:
- `WORD_W`, 32: instruction and address width; only 32 is supported (4 bytes per word).
- `DEPTH`, 256: store size in words; must be a power of 2 and at least 2.
- `NOP_WORD`, 32'h0000_0013: word returned for gated or illegal fetches (`addi x0,x0,0`).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `n_reset` in 1: asynchronous active-low reset.
- `Iaddress` in WORD_W: byte address from the program counter.
- `instr` out WORD_W: fetched instruction.
- `boot_valid` in 1: loader byte present.
- `boot_byte` in 8: loader data byte.
- `boot_last` in 1: qualifies the final byte of the image.
- `boot_ready` out 1: loader byte accepted this cycle if `boot_valid` is high.
- `core_run` out 1: store loaded; the core uses it to release the PC.
- `fault` out 1: illegal fetch flag (see Configuration).

## Operation
- States: `LOAD` → `RUN`. Reset enters `LOAD`.
- `RUN` is left only by reset.
- Handshake: a byte is taken on a rising edge with `boot_valid && boot_ready`. `boot_ready` = (state == `LOAD`).
- Assembly order is little-endian. A 2-bit byte counter selects the lane: byte 0 → [7:0] … byte 3 → [31:24].
- The word is written to the store at `wptr` on the edge accepting byte 3, or on the edge accepting a `boot_last` byte.
  - For a `boot_last` word, unfilled upper lanes are written as 0.
  - After each word write, `wptr` increments and the byte counter clears.
- Transition to `RUN` occurs:
  - on the edge accepting a `boot_last` byte; or
  - on the edge writing word `DEPTH-1` (full store, auto-terminate), with or without `boot_last`.
- Words never written stay undefined; the store is not reset.
- Read:
  - in `LOAD`, `instr` = `NOP_WORD`;
  - in `RUN`, `instr` = `store[Iaddress[2+log2(DEPTH)-1:2]]`, subject to fault gating.
- Idle cycles (`boot_valid` low) change nothing.
- `boot_last` without `boot_valid` is ignored.

## Timing
- Reset values:
  - state `LOAD`, byte counter 0, `wptr` 0;
  - `boot_ready` 1, `core_run` 0, `fault` 0, `instr` = `NOP_WORD`.
- `core_run` and `boot_ready` are decoded from the state register. Both change in the cycle after the terminating edge.
- Read latency is zero: `instr` and `fault` are combinational from `Iaddress` and state.
- The first fetch at `Iaddress` 0 is valid in the same cycle `core_run` rises.
- Reset mid-load discards the partial word and `wptr`. The next accepted byte lands in word 0, lane 0.

## Configuration
Macro `IMEM_FAULT_EN`:

- **Defined:** in `RUN`, `fault` = `Iaddress[1:0] != 0` OR `Iaddress >= DEPTH*4`. When `fault` is 1, `instr` = `NOP_WORD`.
- **Undefined:**
  - `fault` is tied to 0;
  - `Iaddress[1:0]` is ignored;
  - upper address bits are truncated, so fetches wrap modulo `DEPTH*4`.

## Structure
- `imem_pkg` holds:
  - the `imem_state_t` enum (`LOAD`, `RUN`);
  - the default `NOP_WORD` constant;
  - the byte-lane counter width.
- Sub-module `imem_byte_packer` contains the byte counter, lane assembler and `wptr`. It emits a write strobe, write address, write data and a `done` pulse.
- The top level contains the state register, the store array and the read/fault mux.

## Test plan
1. **Basic load and fetch:** after reset, send 13,05,A0,00 with `boot_last` on byte 4.
   - Word 0 = 0x00A00513.
   - `core_run` = 1 the next cycle.
   - With `Iaddress` = 0, `instr` = 0x00A00513.
2. **Partial last word:** send 8 bytes, then 0x93 with `boot_last`.
   - Word 2 = 0x0000_0093.
   - `boot_ready` = 0 from the next cycle.
3. **Gating during load:** during `LOAD`, drive any `Iaddress`.
   - `instr` = 0x0000_0013 and `core_run` = 0.
   - Insert 3 idle cycles mid-word; the assembled word is unchanged.
4. **Full-store auto-terminate:** with `DEPTH` = 4, send 16 bytes with no `boot_last`.
   - `RUN` is entered after byte 16.
   - A 17th byte with `boot_valid` high is not accepted.
5. **Fault handling:**
   - With `IMEM_FAULT_EN` defined: `Iaddress` = 0x2 → `fault` = 1 and NOP; `Iaddress` = `DEPTH*4` → `fault` = 1.
   - Without the macro: `Iaddress` = `DEPTH*4` returns word 0 and `fault` = 0.
6. **Reset mid-load:** pulse `n_reset` low after 6 bytes.
   - `core_run` = 0 and `boot_ready` = 1.
   - Next 4 bytes plus `boot_last` load into word 0.
